// File: rtl/uart_cmd_rx.sv
`timescale 1ns/1ps
// uart_cmd_rx: UART receiver for a command byte stream. 8N1 framing by
// default; defining UART_CMD_RX_PARITY_EN adds an even-parity bit (8E1).
//
// Parameters:
//   CLK_FREQ      sys_clk frequency in Hz
//   BAUD          serial bit rate
// Ports:
//   sys_clk       single clock, rising edge
//   sys_rst_n     asynchronous active-low reset
//   uart_rxd      asynchronous serial input, idle high
//   uart_done     one-cycle strobe: a valid byte was loaded into uart_data_out
//   uart_data_out last valid byte, held until the next valid byte
//   frame_err     one-cycle strobe: frame rejected (bad stop bit or parity)
//   rx_busy       high whenever the receiver is not idle
module uart_cmd_rx #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic       uart_done,
    output logic [7:0] uart_data_out,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned BIT_DIV  = CLK_FREQ / BAUD;
    localparam int unsigned HALF_DIV = BIT_DIV / 2;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

    // Too few clocks per bit to find a bit centre reliably.
    if (BIT_DIV < 16) begin : g_bad_div
        $error("uart_cmd_rx: CLK_FREQ/BAUD must be at least 16");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_CMD_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_data_out;
    logic               r_done;
    logic               r_ferr;
    logic               r_busy;
    logic               r_rx_s1;
    logic               r_rx_s2;
    logic               r_rx_d;
`ifdef UART_CMD_RX_PARITY_EN
    logic               r_par_err;
`endif

    logic               w_rxs;
    logic               w_fall;
    logic               w_stop_ok;

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= uart_rxd;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    assign w_rxs  = r_rx_s2;
    assign w_fall = r_rx_d & ~r_rx_s2;

`ifdef UART_CMD_RX_PARITY_EN
    assign w_stop_ok = w_rxs & ~r_par_err;
`else
    assign w_stop_ok = w_rxs;
`endif

    // Receive state machine; counter restarts on every state change and
    // on every data bit so each sample lands BIT_DIV after the previous one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
            r_par_err  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            r_cnt  <= r_cnt + CNT_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    // Re-check at the start-bit centre to reject short glitches.
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_CMD_RX_PARITY_EN
                S_PARITY: begin
                    // Even parity: data bits plus parity bit must XOR to 0.
                    if (r_cnt == BIT_LAST) begin
                        r_cnt     <= '0;
                        r_par_err <= ^{r_shift, w_rxs};
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= '0;
                        if (w_stop_ok) begin
                            r_data_out <= r_shift;
                            r_done     <= 1'b1;
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                        end else begin
                            r_ferr <= 1'b1;
                            if (w_rxs) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_WAIT_IDLE;
                            end
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    // Hold off until the line is released so a break
                    // reports a single error.
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign uart_done     = r_done;
    assign uart_data_out = r_data_out;
    assign frame_err     = r_ferr;
    assign rx_busy       = r_busy;

endmodule

// File: tb/tb_uart_cmd_rx.sv
`timescale 1ns/1ps
module tb_uart_cmd_rx;

    localparam int unsigned CLK_FREQ = 50000000;
    localparam int unsigned BAUD     = 115200;
    localparam int unsigned BIT_DIV  = CLK_FREQ / BAUD;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       uart_rxd;
    logic       uart_done;
    logic [7:0] uart_data_out;
    logic       frame_err;
    logic       rx_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_ferr  = 0;
    logic [7:0] exp_q[$];

`ifdef UART_CMD_RX_PARITY_EN
    logic tb_par_flip = 1'b0;
`endif

    always #10 sys_clk = ~sys_clk;

    uart_cmd_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .uart_rxd      (uart_rxd),
        .uart_done     (uart_done),
        .uart_data_out (uart_data_out),
        .frame_err     (frame_err),
        .rx_busy       (rx_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_wait();
        repeat (BIT_DIV) @(negedge sys_clk);
    endtask

    // Drives one complete frame starting at a falling clock edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        bit_wait();
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            bit_wait();
        end
`ifdef UART_CMD_RX_PARITY_EN
        uart_rxd = (^b) ^ tb_par_flip;
        bit_wait();
`endif
        uart_rxd = stop_bit;
        bit_wait();
    endtask

    // Output monitor: scoreboard compare on every done strobe.
    always @(negedge sys_clk) begin
        if (uart_done || frame_err)
            check("strobe_exclusive", 32'(uart_done & frame_err), 32'd0);
        if (uart_done) begin
            n_done++;
            check("sb_expected_byte", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("sb_data", 32'(uart_data_out), 32'(exp_q.pop_front()));
        end
        if (frame_err)
            n_ferr++;
    end

    initial begin
        int d0;
        int f0;

        uart_rxd  = 1'b1;
        sys_rst_n = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("rst_done", 32'(uart_done), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_data", 32'(uart_data_out), 32'h00);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);

        // Single byte
        d0 = n_done; f0 = n_ferr;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        bit_wait();
        check("a5_done_cnt", 32'(n_done - d0), 32'd1);
        check("a5_ferr_cnt", 32'(n_ferr - f0), 32'd0);
        check("a5_data", 32'(uart_data_out), 32'hA5);
        check("a5_idle", 32'(rx_busy), 32'd0);

        // Back-to-back frames, no idle gap
        d0 = n_done; f0 = n_ferr;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h55);
        send_frame(8'h10, 1'b1);
        send_frame(8'h55, 1'b1);
        bit_wait();
        check("b2b_done_cnt", 32'(n_done - d0), 32'd2);
        check("b2b_ferr_cnt", 32'(n_ferr - f0), 32'd0);
        check("b2b_data", 32'(uart_data_out), 32'h55);

        // 100-cycle low glitch
        d0 = n_done; f0 = n_ferr;
        uart_rxd = 1'b0;
        repeat (50) @(negedge sys_clk);
        check("glitch_busy_mid", 32'(rx_busy), 32'd1);
        repeat (50) @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (120) @(negedge sys_clk);
        check("glitch_busy_220", 32'(rx_busy), 32'd0);
        bit_wait();
        check("glitch_done_cnt", 32'(n_done - d0), 32'd0);
        check("glitch_ferr_cnt", 32'(n_ferr - f0), 32'd0);

        // Bad stop bit followed by a long break
        d0 = n_done; f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        repeat (5000) @(negedge sys_clk);
        check("brk_ferr_cnt", 32'(n_ferr - f0), 32'd1);
        check("brk_done_cnt", 32'(n_done - d0), 32'd0);
        check("brk_data_kept", 32'(uart_data_out), 32'h55);
        check("brk_busy_low_line", 32'(rx_busy), 32'd1);
        uart_rxd = 1'b1;
        bit_wait();
        check("brk_busy_released", 32'(rx_busy), 32'd0);
        d0 = n_done;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        bit_wait();
        check("post_brk_done_cnt", 32'(n_done - d0), 32'd1);
        check("post_brk_data", 32'(uart_data_out), 32'h01);

        // Reset pulse in the middle of bit 4 of 8'hFF
        d0 = n_done; f0 = n_ferr;
        uart_rxd = 1'b0;
        bit_wait();
        uart_rxd = 1'b1;
        repeat (4) bit_wait();
        repeat (BIT_DIV / 2) @(negedge sys_clk);
        check("pre_rst_busy", 32'(rx_busy), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_done", 32'(uart_done), 32'd0);
        check("mid_rst_ferr", 32'(frame_err), 32'd0);
        check("mid_rst_busy", 32'(rx_busy), 32'd0);
        check("mid_rst_data", 32'(uart_data_out), 32'h00);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (6) bit_wait();
        check("post_rst_done_cnt", 32'(n_done - d0), 32'd0);
        check("post_rst_ferr_cnt", 32'(n_ferr - f0), 32'd0);
        check("post_rst_busy", 32'(rx_busy), 32'd0);
        d0 = n_done;
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        bit_wait();
        check("post_rst_rx_cnt", 32'(n_done - d0), 32'd1);
        check("post_rst_rx_data", 32'(uart_data_out), 32'h12);

`ifdef UART_CMD_RX_PARITY_EN
        // Even parity: 8'h07 needs parity bit 1
        d0 = n_done; f0 = n_ferr;
        tb_par_flip = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        bit_wait();
        check("par_ok_done_cnt", 32'(n_done - d0), 32'd1);
        check("par_ok_ferr_cnt", 32'(n_ferr - f0), 32'd0);
        check("par_ok_data", 32'(uart_data_out), 32'h07);
        d0 = n_done; f0 = n_ferr;
        tb_par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        bit_wait();
        tb_par_flip = 1'b0;
        check("par_bad_done_cnt", 32'(n_done - d0), 32'd0);
        check("par_bad_ferr_cnt", 32'(n_ferr - f0), 32'd1);
        check("par_bad_data_kept", 32'(uart_data_out), 32'h07);
`endif

        for (int i = 0; i < int'(2 * BIT_DIV) && exp_q.size() != 0; i++)
            @(negedge sys_clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
